// File: rtl/rank_order_sorter.sv
// Two-stage rank-order selector: returns the two smallest of four unsigned
// magnitudes in ascending order with their lane indices; ties favour the lower lane.
module rank_order_sorter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] mag_in  [0:3],
    output logic             out_valid,
    output logic [WIDTH-1:0] min_out [0:1],
    output logic [1:0]       min_idx [0:1]
);

    // Strict total order on (value, lane): the lower lane wins ties.
    function automatic logic ranks_below(
        input logic [WIDTH-1:0] va,
        input logic [1:0]       ia,
        input logic [WIDTH-1:0] vb,
        input logic [1:0]       ib
    );
        return (va < vb) || ((va == vb) && (ia < ib));
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] lo_val_q [0:1];
    logic [WIDTH-1:0] lo_val_d [0:1];
    logic [WIDTH-1:0] hi_val_q [0:1];
    logic [WIDTH-1:0] hi_val_d [0:1];
    logic [1:0]       lo_idx_q [0:1];
    logic [1:0]       lo_idx_d [0:1];
    logic [1:0]       hi_idx_q [0:1];
    logic [1:0]       hi_idx_d [0:1];
    logic             pair_swap [0:1];

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] min_val_q [0:1];
    logic [WIDTH-1:0] min_val_d [0:1];
    logic [1:0]       min_idx_q [0:1];
    logic [1:0]       min_idx_d [0:1];

    // Pair gi holds lanes 2*gi (even) and 2*gi+1 (odd); swap when the odd lane ranks below.
    for (genvar gi = 0; gi < 2; gi++) begin : g_pair
        localparam logic [1:0] LANE_E = 2'(2 * gi);
        localparam logic [1:0] LANE_O = 2'(2 * gi + 1);
        assign pair_swap[gi] = ranks_below(mag_in[2*gi+1], LANE_O, mag_in[2*gi], LANE_E);
    end

    always_comb begin
        s1_valid_d = in_valid;
        for (int i = 0; i < 2; i++) begin
            lo_val_d[i] = lo_val_q[i];
            hi_val_d[i] = hi_val_q[i];
            lo_idx_d[i] = lo_idx_q[i];
            hi_idx_d[i] = hi_idx_q[i];
            if (in_valid) begin
                lo_val_d[i] = pair_swap[i] ? mag_in[2*i+1] : mag_in[2*i];
                hi_val_d[i] = pair_swap[i] ? mag_in[2*i]   : mag_in[2*i+1];
                lo_idx_d[i] = 2'(2 * i + (pair_swap[i] ? 1 : 0));
                hi_idx_d[i] = 2'(2 * i + (pair_swap[i] ? 0 : 1));
            end
        end
    end

    logic             a_wins;
    logic [WIDTH-1:0] win_lo_v, lose_lo_v, win_hi_v;
    logic [1:0]       win_lo_i, lose_lo_i, win_hi_i;
    logic             loser_first;

    // The runner-up is either the losing pair's minimum or the winning pair's maximum.
    always_comb begin
        a_wins      = ranks_below(lo_val_q[0], lo_idx_q[0], lo_val_q[1], lo_idx_q[1]);
        win_lo_v    = a_wins ? lo_val_q[0] : lo_val_q[1];
        win_lo_i    = a_wins ? lo_idx_q[0] : lo_idx_q[1];
        lose_lo_v   = a_wins ? lo_val_q[1] : lo_val_q[0];
        lose_lo_i   = a_wins ? lo_idx_q[1] : lo_idx_q[0];
        win_hi_v    = a_wins ? hi_val_q[0] : hi_val_q[1];
        win_hi_i    = a_wins ? hi_idx_q[0] : hi_idx_q[1];
        loser_first = ranks_below(lose_lo_v, lose_lo_i, win_hi_v, win_hi_i);

        out_valid_d  = s1_valid_q;
        min_val_d[0] = min_val_q[0];
        min_val_d[1] = min_val_q[1];
        min_idx_d[0] = min_idx_q[0];
        min_idx_d[1] = min_idx_q[1];
        if (s1_valid_q) begin
            min_val_d[0] = win_lo_v;
            min_idx_d[0] = win_lo_i;
            min_val_d[1] = loser_first ? lose_lo_v : win_hi_v;
            min_idx_d[1] = loser_first ? lose_lo_i : win_hi_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                lo_val_q[i]  <= '0;
                hi_val_q[i]  <= '0;
                lo_idx_q[i]  <= '0;
                hi_idx_q[i]  <= '0;
                min_val_q[i] <= '0;
                min_idx_q[i] <= '0;
            end
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            for (int i = 0; i < 2; i++) begin
                lo_val_q[i]  <= lo_val_d[i];
                hi_val_q[i]  <= hi_val_d[i];
                lo_idx_q[i]  <= lo_idx_d[i];
                hi_idx_q[i]  <= hi_idx_d[i];
                min_val_q[i] <= min_val_d[i];
                min_idx_q[i] <= min_idx_d[i];
            end
        end
    end

    assign out_valid = out_valid_q;
    for (genvar gi = 0; gi < 2; gi++) begin : g_out
        assign min_out[gi] = min_val_q[gi];
        assign min_idx[gi] = min_idx_q[gi];
    end

endmodule

// File: tb/tb_rank_order_sorter.sv
// Scoreboard bench for rank_order_sorter: expected results are queued when a
// sample is driven and compared when the DUT raises out_valid.
module tb_rank_order_sorter;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] mag_in  [0:3];
    logic         out_valid;
    logic [W-1:0] min_out [0:1];
    logic [1:0]   min_idx [0:1];

    typedef struct packed {
        logic [W-1:0] v0;
        logic [W-1:0] v1;
        logic [1:0]   i0;
        logic [1:0]   i1;
    } res_t;

    res_t exp_q[$];
    bit   vpipe0, vpipe1;
    bit   chk_zero;
    int   checks, failures;

    rank_order_sorter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .mag_in   (mag_in),
        .out_valid(out_valid),
        .min_out  (min_out),
        .min_idx  (min_idx)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: pick the overall minimum by a linear scan, then the best of the rest.
    function automatic res_t model(input int m0, input int m1, input int m2, input int m3);
        int   m[4];
        int   best, second;
        res_t r;
        m = '{m0, m1, m2, m3};
        best = 0;
        for (int i = 1; i < 4; i++)
            if (m[i] < m[best]) best = i;
        second = -1;
        for (int i = 0; i < 4; i++)
            if (i != best && (second < 0 || m[i] < m[second])) second = i;
        r.v0 = W'(m[best]);
        r.v1 = W'(m[second]);
        r.i0 = 2'(best);
        r.i1 = 2'(second);
        return r;
    endfunction

    // One cycle: check what the DUT shows now, then drive the next inputs.
    task automatic step(input bit r, input bit v, input int m0, input int m1, input int m2, input int m3);
        res_t e;
        @(negedge clk);
        check_val("out_valid", out_valid, vpipe1);
        if (chk_zero) begin
            check_val("rst_min_out", {min_out[0], min_out[1]}, 0);
            check_val("rst_min_idx", {min_idx[0], min_idx[1]}, 0);
            chk_zero = 0;
        end
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_out", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check_val("min_out0", min_out[0], e.v0);
                check_val("min_out1", min_out[1], e.v1);
                check_val("min_idx0", min_idx[0], e.i0);
                check_val("min_idx1", min_idx[1], e.i1);
            end
        end
        rst       = r;
        in_valid  = v;
        mag_in[0] = W'(m0);
        mag_in[1] = W'(m1);
        mag_in[2] = W'(m2);
        mag_in[3] = W'(m3);
        if (r) begin
            exp_q.delete();
            vpipe0   = 0;
            chk_zero = 1;
        end else if (v) begin
            exp_q.push_back(model(m0, m1, m2, m3));
        end
        vpipe1 = vpipe0;
        vpipe0 = v && !r;
    endtask

    task automatic step_rand(input bit v, input int maxv);
        step(0, v, $urandom_range(0, maxv), $urandom_range(0, maxv),
             $urandom_range(0, maxv), $urandom_range(0, maxv));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        vpipe0   = 0;
        vpipe1   = 0;
        chk_zero = 1;
        rst      = 1;
        in_valid = 0;
        for (int i = 0; i < 4; i++) mag_in[i] = '0;

        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 9, 3, 12, 5);

        step(0, 1, 9, 3, 12, 5);
        step(0, 1, 2, 1, 15, 14);
        step(0, 1, 7, 7, 7, 7);
        step(0, 1, 4, 6, 4, 9);
        step(0, 1, 15, 15, 0, 15);
        step(0, 1, 0, 0, 15, 15);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 15, 14, 13, 12);
        step(0, 0, 1, 1, 1, 1);
        step(0, 0, 1, 1, 1, 1);

        for (int n = 0; n < 100; n++) step_rand(1, (n % 2 == 0) ? 15 : 3);
        for (int n = 0; n < 100; n++) step_rand($urandom_range(0, 1), (n % 2 == 0) ? 15 : 3);

        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 8, 9, 10, 11);
        step(0, 1, 5, 6, 1, 2);
        step(1, 1, 3, 2, 1, 0);
        step(0, 1, 12, 4, 4, 13);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        check_val("drain_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
